// File: rtl/seg7_show_sequencer.sv
// seg7_show_sequencer: control FSM for the 7-segment animation datapath.
// It owns the animation index and the frame-period compare value. It handles
// manual stepping, demo (AUTO) advance after a set number of completed loops,
// idle fallback to AUTO, and the restart/blank handshake on every change.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_MANUAL | user drives the animation; idle timer runs
// ST_AUTO   | loop_done pulses advance the animation
// ST_BLANK  | segments forced off after a change; exits to ret_q when done
module seg7_show_sequencer #(
  parameter int ANI_MAX       = 50,
  parameter int PERIOD_W      = 25,
  parameter int PERIOD_DEF    = 10_000_000,
  parameter int PERIOD_STEP   = 1_000_000,
  parameter int PERIOD_MIN    = 1_000_000,
  parameter int PERIOD_MAX    = 19_000_000,
  parameter int LOOPS_PER_ANI = 3,
  parameter int BLANK_CYCLES  = 1000,
  parameter int IDLE_CYCLES   = 300_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                btn_faster,
  input  logic                btn_slower,
  input  logic                btn_mode,
  input  logic                loop_done,
  output logic [5:0]          animation,
  output logic [PERIOD_W-1:0] period,
  output logic                restart,
  output logic                blank,
  output logic                auto_mode
);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_BLANK  = 2'd2;

  localparam int LOOP_W  = $clog2(LOOPS_PER_ANI + 1);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);

  localparam logic [5:0]          ANI_TOP    = 6'(ANI_MAX);
  localparam logic [LOOP_W-1:0]   LOOP_LAST  = LOOP_W'(LOOPS_PER_ANI - 1);
  localparam logic [BLANK_W-1:0]  BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] STEP_P     = PERIOD_W'(PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] DEF_P      = PERIOD_W'(PERIOD_DEF);
  // Limits held one bit wider so period +/- step can never wrap.
  localparam logic [PERIOD_W:0]   STEP_X     = (PERIOD_W+1)'(PERIOD_STEP);
  localparam logic [PERIOD_W:0]   FAST_LIM_X = (PERIOD_W+1)'(PERIOD_MIN + PERIOD_STEP);
  localparam logic [PERIOD_W:0]   MAX_X      = (PERIOD_W+1)'(PERIOD_MAX);

  logic [1:0]          state_q, state_d;
  logic                ret_q, ret_d;          // 1: return to AUTO after blank
  logic [5:0]          ani_q, ani_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                restart_q, restart_d;
  logic                blank_q, blank_d;
  logic                auto_q, auto_d;

  logic [PERIOD_W:0]   period_x;
  logic [5:0]          ani_inc, ani_dec;
  logic                any_btn, jump;

  // Speed adjust: runs in every state, faster wins over slower.
  always_comb begin
    period_x = {1'b0, period_q};
    period_d = period_q;
    if (btn_faster) begin
      if (period_x >= FAST_LIM_X) period_d = period_q - STEP_P;
    end else if (btn_slower) begin
      if (period_x + STEP_X <= MAX_X) period_d = period_q + STEP_P;
    end
  end

  // Mode FSM, animation stepping and the loop/blank/idle timers.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    ani_d       = ani_q;
    loop_d      = loop_q;
    blank_cnt_d = blank_cnt_q;
    idle_d      = idle_q;
    jump        = 1'b0;
    any_btn     = btn_next | btn_prev | btn_faster | btn_slower | btn_mode;
    ani_inc     = (ani_q == ANI_TOP) ? 6'd0 : ani_q + 6'd1;
    ani_dec     = (ani_q == 6'd0) ? ANI_TOP : ani_q - 6'd1;
    case (state_q)
      ST_MANUAL: begin
        if (btn_mode) begin
          state_d = ST_AUTO;
          loop_d  = '0;
          idle_d  = '0;
        end else if (btn_next || btn_prev) begin
          ani_d  = btn_next ? ani_inc : ani_dec;
          jump   = 1'b1;
          ret_d  = 1'b0;
          idle_d = '0;
        end else if (any_btn) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_AUTO;
          loop_d  = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_AUTO: begin
        if (btn_mode) begin
          state_d = ST_MANUAL;
          idle_d  = '0;
        end else if (btn_next || btn_prev) begin
          // user takes over: blank returns to MANUAL
          ani_d  = btn_next ? ani_inc : ani_dec;
          jump   = 1'b1;
          ret_d  = 1'b0;
          idle_d = '0;
        end else if (loop_done) begin
          if (loop_q == LOOP_LAST) begin
            ani_d  = ani_inc;
            jump   = 1'b1;
            ret_d  = 1'b1;
            loop_d = '0;
          end else begin
            loop_d = loop_q + 1'b1;
          end
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == '0) begin
          state_d = ret_q ? ST_AUTO : ST_MANUAL;
        end else begin
          blank_cnt_d = blank_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
    if (jump) begin
      state_d     = ST_BLANK;
      blank_cnt_d = BLANK_LOAD;
    end
    restart_d = jump;
    blank_d   = (state_d == ST_BLANK);
    auto_d    = (state_d == ST_AUTO) || ((state_d == ST_BLANK) && ret_d);
  end

  // State and output registers; ena low freezes everything but drops restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MANUAL;
      ret_q       <= 1'b0;
      ani_q       <= 6'd0;
      period_q    <= DEF_P;
      loop_q      <= '0;
      blank_cnt_q <= '0;
      idle_q      <= '0;
      restart_q   <= 1'b0;
      blank_q     <= 1'b0;
      auto_q      <= 1'b0;
    end else if (!ena) begin
      restart_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      ani_q       <= ani_d;
      period_q    <= period_d;
      loop_q      <= loop_d;
      blank_cnt_q <= blank_cnt_d;
      idle_q      <= idle_d;
      restart_q   <= restart_d;
      blank_q     <= blank_d;
      auto_q      <= auto_d;
    end
  end

  assign animation = ani_q;
  assign period    = period_q;
  assign restart   = restart_q;
  assign blank     = blank_q;
  assign auto_mode = auto_q;

endmodule

// File: tb/tb_seg7_show_sequencer.sv
// Bench for seg7_show_sequencer: directed table, corner-case sequences and
// random stimulus, all compared against a behavioural model of the controller.
module tb_seg7_show_sequencer;

  localparam int ANI_MAX = 3;
  localparam int P_DEF   = 10;
  localparam int P_STEP  = 2;
  localparam int P_MIN   = 2;
  localparam int P_MAX   = 18;
  localparam int LOOPS   = 2;
  localparam int BLANKS  = 4;
  localparam int IDLES   = 20;
  localparam int PW      = 25;

  // button vector bits: {mode, slower, faster, prev, next}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] NX = 5'b00001;
  localparam logic [4:0] PV = 5'b00010;
  localparam logic [4:0] FA = 5'b00100;
  localparam logic [4:0] SL = 5'b01000;
  localparam logic [4:0] MD = 5'b10000;

  logic clk = 1'b0;
  logic rst_n, ena, btn_next, btn_prev, btn_faster, btn_slower, btn_mode, loop_done;
  logic [5:0] animation;
  logic [PW-1:0] period;
  logic restart, blank, auto_mode;

  int errors = 0;
  int checks = 0;

  seg7_show_sequencer #(
    .ANI_MAX(ANI_MAX), .PERIOD_W(PW), .PERIOD_DEF(P_DEF), .PERIOD_STEP(P_STEP),
    .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX), .LOOPS_PER_ANI(LOOPS),
    .BLANK_CYCLES(BLANKS), .IDLE_CYCLES(IDLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_faster(btn_faster), .btn_slower(btn_slower), .btn_mode(btn_mode),
    .loop_done(loop_done), .animation(animation), .period(period),
    .restart(restart), .blank(blank), .auto_mode(auto_mode)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_ani, m_per, m_bleft, m_loops, m_idle;
  bit m_auto, m_rs;

  task automatic m_reset();
    m_ani = 0; m_per = P_DEF; m_bleft = 0; m_loops = 0; m_idle = 0;
    m_auto = 0; m_rs = 0;
  endtask

  // change animation by d (mod ANI_MAX+1), blank, and land in AUTO if ret
  task automatic m_jump(input int d, input bit ret);
    m_ani = (m_ani + d + ANI_MAX + 1) % (ANI_MAX + 1);
    m_rs = 1; m_bleft = BLANKS; m_auto = ret;
  endtask

  task automatic m_edge(input logic [4:0] b, input logic ld, input logic en);
    m_rs = 0;
    if (!en) return;
    if (b[2]) begin
      if (m_per - P_STEP >= P_MIN) m_per -= P_STEP;
    end else if (b[3]) begin
      if (m_per + P_STEP <= P_MAX) m_per += P_STEP;
    end
    if (m_bleft > 0) begin
      m_bleft--;
    end else if (!m_auto) begin
      if (b[4]) begin m_auto = 1; m_loops = 0; m_idle = 0; end
      else if (b[0] || b[1]) begin m_jump(b[0] ? 1 : -1, 0); m_idle = 0; end
      else if (b[2] || b[3]) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == IDLES) begin m_auto = 1; m_loops = 0; m_idle = 0; end
      end
    end else begin
      if (b[4]) begin m_auto = 0; m_idle = 0; end
      else if (b[0] || b[1]) begin m_jump(b[0] ? 1 : -1, 0); m_idle = 0; end
      else if (ld) begin
        m_loops++;
        if (m_loops == LOOPS) begin m_loops = 0; m_jump(1, 1); end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("animation", int'(animation), m_ani);
    chk("period", int'(period), m_per);
    chk("restart", int'(restart), int'(m_rs));
    chk("blank", int'(blank), int'(m_bleft > 0));
    chk("auto_mode", int'(auto_mode), int'(m_auto));
  endtask

  task automatic cyc(input logic [4:0] b, input logic ld, input logic en);
    {btn_mode, btn_slower, btn_faster, btn_prev, btn_next} = b;
    loop_done = ld;
    ena = en;
    @(posedge clk);
    m_edge(b, ld, en);
    #1;
    cmp_model();
    {btn_mode, btn_slower, btn_faster, btn_prev, btn_next} = NO;
    loop_done = 1'b0;
    ena = 1'b1;
  endtask

  typedef struct {
    logic [4:0] b;
    int ani; int per; int rs; int bl; int am;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [4:0] b, input int ani, input int per,
                     input int rs, input int bl, input int am);
    vec_t v;
    v.b = b; v.ani = ani; v.per = per; v.rs = rs; v.bl = bl; v.am = am;
    tbl.push_back(v);
  endtask

  initial begin
    int cnt, budget;
    logic [4:0] rb;

    rst_n = 1'b0; ena = 1'b1; loop_done = 1'b0;
    {btn_mode, btn_slower, btn_faster, btn_prev, btn_next} = NO;
    m_reset();
    #12;
    chk("reset_animation", int'(animation), 0);
    chk("reset_period", int'(period), P_DEF);
    chk("reset_restart", int'(restart), 0);
    chk("reset_blank", int'(blank), 0);
    chk("reset_auto", int'(auto_mode), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // wrap both ways with blank/restart timing, then period clamps
    add(PV, 3, 10, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(NO, 3, 10, 0, 1, 0);
    add(NO, 3, 10, 0, 0, 0);
    add(NX, 0, 10, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(NO, 0, 10, 0, 1, 0);
    add(NO, 0, 10, 0, 0, 0);
    add(FA, 0, 8, 0, 0, 0); add(FA, 0, 6, 0, 0, 0); add(FA, 0, 4, 0, 0, 0);
    add(FA, 0, 2, 0, 0, 0); add(FA, 0, 2, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(SL, 0, 4 + 2 * i, 0, 0, 0);
    add(SL, 0, 18, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(FA, 0, 16 - 2 * i, 0, 0, 0);
    add(FA | SL, 0, 8, 0, 0, 0);
    add(SL, 0, 10, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].b, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_ani", i), int'(animation), tbl[i].ani);
      chk($sformatf("tbl%0d_period", i), int'(period), tbl[i].per);
      chk($sformatf("tbl%0d_restart", i), int'(restart), tbl[i].rs);
      chk($sformatf("tbl%0d_blank", i), int'(blank), tbl[i].bl);
      chk($sformatf("tbl%0d_auto", i), int'(auto_mode), tbl[i].am);
    end

    // AUTO: advance on every 2nd loop_done
    cyc(MD, 1'b0, 1'b1);
    chk("auto_enter", int'(auto_mode), 1);
    for (int p = 1; p <= 4; p++) begin
      cyc(NO, 1'b1, 1'b1);
      cnt = int'(blank);
      if (p == 2) begin chk("auto_adv1", int'(animation), 1); chk("auto_rs1", int'(restart), 1); end
      if (p == 4) begin chk("auto_adv2", int'(animation), 2); chk("auto_rs2", int'(restart), 1); end
      for (int k = 0; k < 9; k++) begin cyc(NO, 1'b0, 1'b1); cnt += int'(blank); end
      chk($sformatf("auto_blank_len_p%0d", p), cnt, (p % 2 == 0) ? 4 : 0);
      chk($sformatf("auto_after_p%0d", p), int'(auto_mode), 1);
    end

    // inputs dropped during blank, speed still applies
    cyc(NO, 1'b1, 1'b1);
    cyc(NO, 1'b1, 1'b1);
    chk("blk_adv", int'(animation), 3);
    cnt = int'(blank);
    cyc(NX | SL, 1'b1, 1'b1);
    cnt += int'(blank);
    chk("blk_ignore_next", int'(animation), 3);
    chk("blk_slower", int'(period), 12);
    for (int k = 0; k < 4; k++) begin cyc(NO, 1'b0, 1'b1); cnt += int'(blank); end
    chk("blk_len", cnt, 4);
    cyc(NO, 1'b1, 1'b1);
    chk("blk_loop_not_counted", int'(animation), 3);
    cyc(NO, 1'b1, 1'b1);
    chk("blk_loop_adv", int'(animation), 0);
    for (int k = 0; k < 4; k++) cyc(NO, 1'b0, 1'b1);

    // idle fallback, and a speed press restarting the idle count
    cyc(MD, 1'b0, 1'b1);
    chk("idle_manual", int'(auto_mode), 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(NO, 1'b0, 1'b1);
      if (i >= 19) chk($sformatf("idle_c%0d", i), int'(auto_mode), int'(i == 20));
    end
    cyc(MD, 1'b0, 1'b1);
    for (int i = 1; i <= 35; i++) begin
      cyc((i == 15) ? FA : NO, 1'b0, 1'b1);
      if (i == 20 || i >= 34) chk($sformatf("idle2_c%0d", i), int'(auto_mode), int'(i == 35));
    end

    // async reset mid-blank in AUTO
    cyc(NO, 1'b1, 1'b1);
    cyc(NO, 1'b1, 1'b1);
    cyc(NO, 1'b0, 1'b1);
    chk("pre_rst_blank", int'(blank), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ani", int'(animation), 0);
    chk("rst_period", int'(period), P_DEF);
    chk("rst_blank", int'(blank), 0);
    chk("rst_auto", int'(auto_mode), 0);
    m_reset();
    @(posedge clk); #1; rst_n = 1'b1;

    // ena low during blank stretches it
    cyc(NX, 1'b0, 1'b1);
    cnt = int'(blank);
    cyc(NO, 1'b0, 1'b1);
    cnt += int'(blank);
    for (int k = 0; k < 5; k++) begin cyc(NX, 1'b1, 1'b0); cnt += int'(blank); end
    budget = 0;
    while (blank && budget < 20) begin cyc(NO, 1'b0, 1'b1); cnt += int'(blank); budget++; end
    if (budget >= 20) chk("ena_blank_timeout", 1, 0);
    chk("ena_blank_len", cnt, 9);
    chk("ena_ani", int'(animation), 1);

    // random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      rb = NO;
      for (int k = 0; k < 5; k++) rb[k] = ($urandom_range(15) == 0);
      cyc(rb, ($urandom_range(5) == 0), ($urandom_range(9) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
